// File: rtl/oam_dma_if.sv
// Shared-bus signal bundle between the CPU side and the sprite OAM DMA engine.
// master = DMA engine, slave = CPU/bus-mux side.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_R_nW;
    logic [7:0]  Data_bus_in;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic        dma_R_nW;
    logic        dma_active;
    logic        cpu_halt;

    modport master (
        input  cpu_addr, cpu_data_out, cpu_R_nW, Data_bus_in,
        output dma_addr, dma_data_out, dma_R_nW, dma_active, cpu_halt
    );

    modport slave (
        output cpu_addr, cpu_data_out, cpu_R_nW, Data_bus_in,
        input  dma_addr, dma_data_out, dma_R_nW, dma_active, cpu_halt
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a CPU write to $4014 copies page $XX00-$XXFF to $2004 as read/write pairs.
// Define OAM_DMA_ALIGN_EN to add the parity register and the ALIGN cycle (513/514-cycle transfers).
module oam_dma (
    input  logic         clk_ph1,
    input  logic         rst,
    oam_dma_if.master    bus
);
    localparam logic [15:0] TRIG_ADDR = 16'h4014;
    localparam logic [15:0] DEST_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_page, w_page_next;
    logic [7:0] r_idx, w_idx_next;
    logic [7:0] r_latch, w_latch_next;
    logic       w_trig;

`ifdef OAM_DMA_ALIGN_EN
    logic       r_parity;
`endif

    // Exact decode: no mirroring, reads of $4014 ignored.
    assign w_trig = (r_state == S_IDLE) && !bus.cpu_R_nW && (bus.cpu_addr == TRIG_ADDR);

    always_ff @(posedge clk_ph1 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_page  <= 8'h00;
            r_idx   <= 8'h00;
            r_latch <= 8'h00;
`ifdef OAM_DMA_ALIGN_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_page  <= w_page_next;
            r_idx   <= w_idx_next;
            r_latch <= w_latch_next;
`ifdef OAM_DMA_ALIGN_EN
            r_parity <= ~r_parity;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_page_next  = r_page;
        w_idx_next   = r_idx;
        w_latch_next = r_latch;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_page_next  = bus.cpu_data_out;
                    w_idx_next   = 8'h00;
                    w_state_next = S_HALT;
                end
            end
            S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                // Reads must land on even cycles; an even HALT needs one filler cycle.
                w_state_next = r_parity ? S_READ : S_ALIGN;
`else
                w_state_next = S_READ;
`endif
            end
            S_ALIGN: w_state_next = S_READ;
            S_READ: begin
                w_latch_next = bus.Data_bus_in;
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                // idx wraps inside the page; there is no carry into page.
                if (r_idx == 8'hFF) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_idx_next   = r_idx + 8'd1;
                    w_state_next = S_READ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bus outputs decode from registers only, so the mux select has no input-to-output path.
    always_comb begin
        bus.dma_addr     = 16'h0000;
        bus.dma_data_out = 8'h00;
        bus.dma_R_nW     = 1'b1;
        case (r_state)
            S_HALT, S_ALIGN: bus.dma_addr = {r_page, 8'h00};
            S_READ:          bus.dma_addr = {r_page, r_idx};
            S_WRITE: begin
                bus.dma_addr     = DEST_ADDR;
                bus.dma_R_nW     = 1'b0;
                bus.dma_data_out = r_latch;
            end
            default: ;
        endcase
    end

    assign bus.dma_active = (r_state != S_IDLE);
    assign bus.cpu_halt   = (r_state != S_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: full transfers at both start parities, data pattern,
// page $FF, non-trigger accesses and asynchronous reset mid-transfer.
module tb_oam_dma;
    logic clk_ph1;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    oam_dma_if bus ();

    oam_dma dut (
        .clk_ph1 (clk_ph1),
        .rst     (rst),
        .bus     (bus.master)
    );

    initial clk_ph1 = 1'b0;
    always #5 clk_ph1 = ~clk_ph1;

    // Posedges since reset release; bit 0 is the parity of the current cycle.
    always @(posedge clk_ph1 or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        if (a[15:8] == 8'h03) return a[7:0] ^ 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    always_comb bus.Data_bus_in = bus.dma_R_nW ? mem_f(bus.dma_addr) : 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cpu_idle();
        bus.cpu_addr     = 16'h0000;
        bus.cpu_data_out = 8'h00;
        bus.cpu_R_nW     = 1'b1;
    endtask

    // {active, addr, R_nW, data}; data only carries meaning on write cycles.
    function automatic logic [25:0] exp_op(input logic [7:0] pg, input bit al, input int n);
        int m;
        logic [7:0] i;
        if (n == 0 || (al && n == 1)) return {1'b1, pg, 8'h00, 1'b1, 8'h00};
        m = n - 1 - int'(al);
        i = 8'(m / 2);
        if (m % 2 == 0) return {1'b1, pg, i, 1'b1, 8'h00};
        return {1'b1, 16'h2004, 1'b0, mem_f({pg, i})};
    endfunction

    function automatic logic [25:0] obs_op();
        return {bus.dma_active, bus.dma_addr, bus.dma_R_nW,
                bus.dma_R_nW ? 8'h00 : bus.dma_data_out};
    endfunction

    // Call at a negedge; returns at the negedge of the first IDLE cycle afterwards.
    task automatic run_xfer(input logic [7:0] pg, input string tag);
        int n;
        bit al;
        bus.cpu_addr     = 16'h4014;
        bus.cpu_data_out = pg;
        bus.cpu_R_nW     = 1'b0;
        @(posedge clk_ph1);
        #1 cpu_idle();
        @(negedge clk_ph1);
`ifdef OAM_DMA_ALIGN_EN
        al = (cyc[0] == 1'b0);
`else
        al = 1'b0;
`endif
        n = 0;
        while (bus.cpu_halt && n < 600) begin
            check_eq({tag, "_op"}, 32'(obs_op()), 32'(exp_op(pg, al, n)));
            n++;
            @(negedge clk_ph1);
        end
        check_eq({tag, "_len"}, n, 513 + int'(al));
        check_eq({tag, "_idle"}, {bus.dma_addr, bus.dma_data_out, bus.dma_R_nW, bus.dma_active, bus.cpu_halt},
                 {16'h0000, 8'h00, 1'b1, 1'b0, 1'b0});
        $display("xfer %s page=%02h align=%0d halted=%0d cycles", tag, pg, al, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"}, bus.dma_addr, 16'h0000);
        check_eq({tag, "_data"}, bus.dma_data_out, 8'h00);
        check_eq({tag, "_rnw"}, bus.dma_R_nW, 1'b1);
        check_eq({tag, "_active"}, bus.dma_active, 1'b0);
        check_eq({tag, "_halt"}, bus.cpu_halt, 1'b0);
    endtask

    task automatic cpu_access(input logic [15:0] a, input logic [7:0] d, input logic rnw, input string tag);
        bus.cpu_addr     = a;
        bus.cpu_data_out = d;
        bus.cpu_R_nW     = rnw;
        @(posedge clk_ph1);
        #1 cpu_idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_ph1);
            check_eq(tag, {bus.dma_active, bus.cpu_halt, bus.dma_addr}, {1'b0, 1'b0, 16'h0000});
        end
        $display("cpu %s addr=%04h data=%02h rnw=%0d", tag, a, d, rnw);
    endtask

    initial begin
        bit found;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        cpu_idle();
        repeat (3) @(negedge clk_ph1);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk_ph1);
        check_reset_outputs("post_reset");

        // Trigger at even cyc -> HALT cycle odd.
        if (cyc[0] != 1'b0) @(negedge clk_ph1);
        run_xfer(8'h02, "even_start");

        // Trigger at odd cyc -> HALT cycle even.
        if (cyc[0] != 1'b1) @(negedge clk_ph1);
        run_xfer(8'h02, "odd_start");

        // Back-to-back: each trigger lands on the first IDLE cycle.
        run_xfer(8'h03, "pattern");
        run_xfer(8'hFF, "page_ff");

        cpu_access(16'h4015, 8'h02, 1'b0, "wr_4015");
        cpu_access(16'h4014, 8'h02, 1'b1, "rd_4014");

        // Abort at the READ of idx $40.
        bus.cpu_addr     = 16'h4014;
        bus.cpu_data_out = 8'h05;
        bus.cpu_R_nW     = 1'b0;
        @(posedge clk_ph1);
        #1 cpu_idle();
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk_ph1);
            if (bus.dma_addr == 16'h0540 && bus.dma_R_nW) found = 1'b1;
        end
        check_eq("rst_reach_idx40", found, 1'b1);
        rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk_ph1);
        rst = 1'b0;
        $display("reset mid-transfer at page=05 idx=40");
        @(negedge clk_ph1);
        run_xfer(8'h03, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
